// File: rtl/wb_pkg.sv
// ==========================================================================
// wb_pkg : write-back stage constants (source selects, load funct3 codes)
// Rev 1.0
// ==========================================================================
`default_nettype none

package wb_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int RA_W_DEFAULT = 5;

   localparam int WBSEL_MEM = 0;
   localparam int WBSEL_ALU = 1;
   localparam int WBSEL_NPC = 2;
   localparam int WBSEL_CSR = 3;

   typedef logic [2:0] funct3_t;

   localparam funct3_t LD_LB  = 3'b000;
   localparam funct3_t LD_LH  = 3'b001;
   localparam funct3_t LD_LW  = 3'b010;
   localparam funct3_t LD_LBU = 3'b100;
   localparam funct3_t LD_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/wb_stage_pipe_if.sv
// ==========================================================================
// wb_stage_pipe_if : MEM-side handshake plus register-file write/forward port
// Rev 1.0
// ==========================================================================
`default_nettype none

interface wb_stage_pipe_if #(
   parameter int XLEN    = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2,
   parameter int RA_W    = 5,
   parameter int CNT_W   = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        in_wbsel;
   logic [NUM_SRC*XLEN-1:0] in_src;
   logic [2:0]              in_funct3;
   logic [1:0]              in_byte_off;
   logic [RA_W-1:0]         in_rd;
   logic                    in_reg_wen;
   logic                    flush;
   logic                    rf_stall;
   logic                    rf_wen;
   logic [RA_W-1:0]         rf_waddr;
   logic [XLEN-1:0]         rf_wdata;
   logic                    fwd_valid;
   logic [RA_W-1:0]         fwd_rd;
   logic [XLEN-1:0]         fwd_data;
   logic                    sel_err;
   logic [CNT_W-1:0]        commit_cnt;

   modport master (
      output in_valid, in_wbsel, in_src, in_funct3, in_byte_off, in_rd, in_reg_wen,
             flush, rf_stall,
      input  in_ready, rf_wen, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data,
             sel_err, commit_cnt
   );

   modport slave (
      input  in_valid, in_wbsel, in_src, in_funct3, in_byte_off, in_rd, in_reg_wen,
             flush, rf_stall,
      output in_ready, rf_wen, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data,
             sel_err, commit_cnt
   );
endinterface

`default_nettype wire

// File: rtl/wb_load_align.sv
// ==========================================================================
// wb_load_align : picks the addressed byte/half of a load word and extends it
// Rev 1.0
// ==========================================================================
`default_nettype none

module wb_load_align
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  funct3_t         funct3_i,
   input  logic [1:0]      byte_off_i,
   input  logic [XLEN-1:0] word_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
   // Halfword lane only follows off[1]; misaligned off[0] is ignored.
   assign half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      data_o = word_i;
      case (funct3_i)
         LD_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LD_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         LD_LW:   data_o = word_i;
         LD_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
         LD_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/wb_stage_pipe.sv
// ==========================================================================
// wb_stage_pipe : two-stage write-back (raw capture, then selected result)
// Rev 1.0
// ==========================================================================
`default_nettype none

module wb_stage_pipe
   import wb_pkg::*;
#(
   parameter int XLEN    = XLEN_DEFAULT,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2,
   parameter int RA_W    = RA_W_DEFAULT,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   wb_stage_pipe_if.slave    bus
);

   logic                    s1_valid_q, s1_valid_d;
   logic [SEL_W-1:0]        s1_wbsel_q, s1_wbsel_d;
   logic [NUM_SRC*XLEN-1:0] s1_src_q, s1_src_d;
   funct3_t                 s1_funct3_q, s1_funct3_d;
   logic [1:0]              s1_off_q, s1_off_d;
   logic [RA_W-1:0]         s1_rd_q, s1_rd_d;
   logic                    s1_wen_q, s1_wen_d;

   logic                    s2_valid_q, s2_valid_d;
   logic                    s2_wen_q, s2_wen_d;
   logic [RA_W-1:0]         s2_rd_q, s2_rd_d;
   logic [XLEN-1:0]         s2_data_q, s2_data_d;
   logic                    sel_err_q, sel_err_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    s2_ready, s1_ready, accept, s1_adv, sel_ok, rf_wen;
   logic [XLEN-1:0]         load_data, sel_data;

   assign s2_ready = !s2_valid_q || !bus.rf_stall;
   assign s1_ready = !s1_valid_q || s2_ready;
   assign accept   = bus.in_valid && s1_ready;
   // A flushed S1 entry must not slip into S2 on the same edge.
   assign s1_adv   = s1_valid_q && s2_ready && !bus.flush;
   assign sel_ok   = int'(s1_wbsel_q) < NUM_SRC;
   assign rf_wen   = s2_valid_q && s2_wen_q && (s2_rd_q != '0) && !bus.rf_stall;

   wb_load_align #(.XLEN(XLEN)) u_load_align (
      .funct3_i   (s1_funct3_q),
      .byte_off_i (s1_off_q),
      .word_i     (s1_src_q[WBSEL_MEM*XLEN +: XLEN]),
      .data_o     (load_data)
   );

   always_comb begin
      sel_data = '0;
      if (sel_ok) begin
         if (int'(s1_wbsel_q) == WBSEL_MEM) sel_data = load_data;
         for (int k = 1; k < NUM_SRC; k++) begin
            if (int'(s1_wbsel_q) == k) sel_data = s1_src_q[k*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_wbsel_d  = s1_wbsel_q;
      s1_src_d    = s1_src_q;
      s1_funct3_d = s1_funct3_q;
      s1_off_d    = s1_off_q;
      s1_rd_d     = s1_rd_q;
      s1_wen_d    = s1_wen_q;
      s2_valid_d  = s2_valid_q;
      s2_wen_d    = s2_wen_q;
      s2_rd_d     = s2_rd_q;
      s2_data_d   = s2_data_q;
      sel_err_d   = s1_adv && !sel_ok;
      cnt_d       = cnt_q + CNT_W'(rf_wen);

      if (accept) begin
         s1_wbsel_d  = bus.in_wbsel;
         s1_src_d    = bus.in_src;
         s1_funct3_d = bus.in_funct3;
         s1_off_d    = bus.in_byte_off;
         s1_rd_d     = bus.in_rd;
         s1_wen_d    = bus.in_reg_wen;
      end
      if (bus.flush)    s1_valid_d = 1'b0;
      else if (accept)  s1_valid_d = 1'b1;
      else if (s1_adv)  s1_valid_d = 1'b0;

      if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_wen_d   = s1_wen_q && sel_ok;
         s2_rd_d    = s1_rd_q;
         s2_data_d  = sel_data;
      end else if (!bus.rf_stall) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_wbsel_q  <= '0;
         s1_src_q    <= '0;
         s1_funct3_q <= '0;
         s1_off_q    <= '0;
         s1_rd_q     <= '0;
         s1_wen_q    <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_wen_q    <= 1'b0;
         s2_rd_q     <= '0;
         s2_data_q   <= '0;
         sel_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_wbsel_q  <= s1_wbsel_d;
         s1_src_q    <= s1_src_d;
         s1_funct3_q <= s1_funct3_d;
         s1_off_q    <= s1_off_d;
         s1_rd_q     <= s1_rd_d;
         s1_wen_q    <= s1_wen_d;
         s2_valid_q  <= s2_valid_d;
         s2_wen_q    <= s2_wen_d;
         s2_rd_q     <= s2_rd_d;
         s2_data_q   <= s2_data_d;
         sel_err_q   <= sel_err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_ready   = s1_ready;
   assign bus.rf_wen     = rf_wen;
   assign bus.rf_waddr   = s2_rd_q;
   assign bus.rf_wdata   = s2_data_q;
   assign bus.fwd_valid  = s2_valid_q && s2_wen_q && (s2_rd_q != '0);
   assign bus.fwd_rd     = s2_rd_q;
   assign bus.fwd_data   = s2_data_q;
   assign bus.sel_err    = sel_err_q;
   assign bus.commit_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
// ==========================================================================
// tb_wb_stage_pipe : directed stimulus with a write-order scoreboard
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_wb_stage_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_stage_pipe_if #(.XLEN(32), .NUM_SRC(4), .SEL_W(2), .RA_W(5), .CNT_W(32)) a ();
   wb_stage_pipe_if #(.XLEN(32), .NUM_SRC(3), .SEL_W(2), .RA_W(5), .CNT_W(32)) b ();

   wb_stage_pipe #(.XLEN(32), .NUM_SRC(4), .SEL_W(2), .RA_W(5), .CNT_W(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (a.slave)
   );

   wb_stage_pipe #(.XLEN(32), .NUM_SRC(3), .SEL_W(2), .RA_W(5), .CNT_W(32)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   exp_cnt  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every register-file write must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && a.rf_wen) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write",
                     a.rf_waddr, a.rf_wdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_addr", 64'(a.rf_waddr), 64'(e.rd));
            chk("wb_data", 64'(a.rf_wdata), 64'(e.data));
            chk("fwd_data", 64'(a.fwd_data), 64'(e.data));
         end
      end
   end

   task automatic send(input int sel, input logic [31:0] val, input logic [2:0] f3,
                       input logic [1:0] off, input logic [4:0] rd, input bit wen,
                       input logic [31:0] exp, input bit push);
      logic [127:0] s;
      bit           accepted;
      int           n;
      for (int k = 0; k < 4; k++)
         s[k*32 +: 32] = (k == sel) ? val : (32'hC0DE_0000 | 32'(k));
      a.in_valid    = 1'b1;
      a.in_wbsel    = 2'(sel);
      a.in_src      = s;
      a.in_funct3   = f3;
      a.in_byte_off = off;
      a.in_rd       = rd;
      a.in_reg_wen  = wen;
      accepted = 1'b0;
      n = 0;
      while (!accepted && n < 20) begin
         @(negedge clk);
         if (a.in_ready) accepted = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      if (!accepted) chk("accept_timeout", 64'(0), 64'(1));
      else if (push) begin
         sb.push_back('{rd: rd, data: exp});
         exp_cnt++;
      end
   endtask

   task automatic idle();
      a.in_valid = 1'b0;
   endtask

   task automatic drain_and_check(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
      @(posedge clk);
      #1;
      chk(name, 64'(a.commit_cnt), 64'(exp_cnt));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   logic [2:0]  ld_f3  [8] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010, 3'b100, 3'b001, 3'b011};
   logic [1:0]  ld_off [8] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
   logic [31:0] ld_exp [8] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF,
                               32'h80FF_7F01, 32'h0000_0080, 32'h0000_7F01, 32'h80FF_7F01};

   initial begin
      a.in_valid = 0; a.in_wbsel = 0; a.in_src = '0; a.in_funct3 = 0; a.in_byte_off = 0;
      a.in_rd = 0; a.in_reg_wen = 0; a.flush = 0; a.rf_stall = 0;
      b.in_valid = 0; b.in_wbsel = 0; b.in_src = '0; b.in_funct3 = 0; b.in_byte_off = 0;
      b.in_rd = 0; b.in_reg_wen = 0; b.flush = 0; b.rf_stall = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_rf_wen", 64'(a.rf_wen), 0);
      chk("rst_fwd_valid", 64'(a.fwd_valid), 0);
      chk("rst_sel_err", 64'(a.sel_err), 0);
      chk("rst_data", 64'({a.rf_waddr, a.rf_wdata, a.fwd_rd, a.fwd_data} != '0), 0);
      chk("rst_commit_cnt", 64'(a.commit_cnt), 0);
      chk("rst_in_ready", 64'(a.in_ready), 1);
      @(posedge clk);
      #1;

      // Basic ALU write and its latency.
      send(1, 32'h0000_1234, 3'b000, 2'd0, 5'd5, 1'b1, 32'h0000_1234, 1'b1);
      idle();
      @(negedge clk);
      chk("lat_wen_s1", 64'(a.rf_wen), 0);
      @(negedge clk);
      chk("lat_wen_s2", 64'(a.rf_wen), 1);
      drain_and_check("cnt_after_alu");

      // Load formatting from a single memory word.
      for (int i = 0; i < 8; i++)
         send(0, 32'h80FF_7F01, ld_f3[i], ld_off[i], 5'(i + 1), 1'b1, ld_exp[i], 1'b1);
      idle();
      drain_and_check("cnt_after_loads");

      // Back-to-back with a 3-cycle register-file stall.
      fork
         begin
            for (int i = 0; i < 4; i++)
               send(1, 32'hA000_0001 + 32'(i), 3'b000, 2'd0, 5'(i + 1), 1'b1,
                    32'hA000_0001 + 32'(i), 1'b1);
            idle();
         end
         begin
            repeat (2) @(posedge clk);
            #1 a.rf_stall = 1'b1;
            @(negedge clk);
            chk("stall_in_ready", 64'(a.in_ready), 0);
            chk("stall_fwd_valid", 64'(a.fwd_valid), 1);
            chk("stall_fwd_rd", 64'(a.fwd_rd), 1);
            chk("stall_rf_wen", 64'(a.rf_wen), 0);
            repeat (3) @(posedge clk);
            #1 a.rf_stall = 1'b0;
         end
      join
      drain_and_check("cnt_after_stall");

      // Write to x0 never issues.
      send(2, 32'h0000_0100, 3'b000, 2'd0, 5'd0, 1'b1, 32'h0, 1'b0);
      idle();
      @(negedge clk);
      @(negedge clk);
      chk("x0_fwd_valid", 64'(a.fwd_valid), 0);
      chk("x0_rf_wen", 64'(a.rf_wen), 0);
      drain_and_check("cnt_after_x0");

      // Flush: S2 entry completes, S1 entry and same-cycle accept are dropped.
      send(1, 32'h0000_0055, 3'b000, 2'd0, 5'd10, 1'b1, 32'h0000_0055, 1'b1);
      send(1, 32'h0000_0066, 3'b000, 2'd0, 5'd11, 1'b1, 32'h0, 1'b0);
      a.flush = 1'b1;
      send(1, 32'h0000_0077, 3'b000, 2'd0, 5'd12, 1'b1, 32'h0, 1'b0);
      a.flush = 1'b0;
      idle();
      repeat (5) @(posedge clk);
      drain_and_check("cnt_after_flush");

      // Out-of-range select on the three-source build.
      b.in_valid = 1'b1; b.in_wbsel = 2'd3; b.in_rd = 5'd9; b.in_reg_wen = 1'b1;
      b.in_src = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      @(negedge clk);
      chk("b_in_ready", 64'(b.in_ready), 1);
      @(posedge clk);
      #1 b.in_valid = 1'b0;
      @(negedge clk);
      chk("b_sel_err_s1", 64'(b.sel_err), 0);
      @(negedge clk);
      chk("b_sel_err", 64'(b.sel_err), 1);
      chk("b_bad_rf_wen", 64'(b.rf_wen), 0);
      chk("b_bad_rf_wdata", 64'(b.rf_wdata), 0);
      chk("b_bad_fwd_valid", 64'(b.fwd_valid), 0);
      @(negedge clk);
      chk("b_sel_err_pulse", 64'(b.sel_err), 0);
      @(posedge clk);
      #1 b.in_valid = 1'b1; b.in_wbsel = 2'd2;
      @(posedge clk);
      #1 b.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b_good_rf_wen", 64'(b.rf_wen), 1);
      chk("b_good_rf_wdata", 64'(b.rf_wdata), 64'h3333_3333);
      chk("b_good_sel_err", 64'(b.sel_err), 0);
      @(posedge clk);
      #1;
      chk("b_commit_cnt", 64'(b.commit_cnt), 1);

      // Forwarding during a stall, then reset in the middle of it.
      a.rf_stall = 1'b1;
      send(3, 32'hDEAD_BEEF, 3'b000, 2'd0, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1);
      send(1, 32'h0000_0099, 3'b000, 2'd0, 5'd8, 1'b1, 32'h0000_0099, 1'b1);
      idle();
      @(negedge clk);
      chk("fwd_valid", 64'(a.fwd_valid), 1);
      chk("fwd_rd", 64'(a.fwd_rd), 7);
      chk("fwd_data_stall", 64'(a.fwd_data), 64'hDEAD_BEEF);
      chk("fwd_in_ready", 64'(a.in_ready), 0);
      #2 rst = 1'b1;
      sb.delete();
      exp_cnt = 0;
      @(posedge clk);
      #1;
      chk("mid_rst_rf_wen", 64'(a.rf_wen), 0);
      chk("mid_rst_fwd_valid", 64'(a.fwd_valid), 0);
      chk("mid_rst_data", 64'({a.rf_waddr, a.rf_wdata, a.fwd_rd, a.fwd_data} != '0), 0);
      chk("mid_rst_commit_cnt", 64'(a.commit_cnt), 0);
      chk("mid_rst_sel_err", 64'(a.sel_err), 0);
      rst = 1'b0;
      a.rf_stall = 1'b0;
      @(posedge clk);
      #1;
      send(1, 32'h0BAD_F00D, 3'b000, 2'd0, 5'd3, 1'b1, 32'h0BAD_F00D, 1'b1);
      idle();
      drain_and_check("cnt_after_reset");

      chk("sb_empty", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
